// File: rtl/cpld_uart_responder.sv
// Responder side of the CPLD parallel UART handshake, bridged to an 8N1 serial line.
// The bidirectional data lane is split into in/out/enable; the tristate lives at the board top.
module cpld_uart_responder #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  input  logic [7:0] uart_data_i,
  output logic [7:0] uart_data_o,
  output logic       uart_data_oe,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd
);
  // state   | meaning (same encoding for TX and RX)
  // S_IDLE  | line idle / waiting for work
  // S_START | start bit (TX drives 0, RX waits half a bit to confirm)
  // S_DATA  | eight data bits, LSB first
  // S_STOP  | stop bit
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic       rdn_s1, rdn_s2, rdn_prev;
  logic       wrn_s1, wrn_s2, wrn_prev;
  logic       rxd_s1, rxd_s2;
  logic [7:0] data_d1, data_d2;
  logic       wr_evt;
  logic [7:0] wr_byte;

  state_t          tx_state, rx_state;
  logic [CW-1:0]   tx_cnt, rx_cnt;
  logic [2:0]      tx_bit, rx_bit;
  logic [7:0]      tx_shift, rx_shift, thr, rbr;

  logic rd_rise;
  logic tx_load;

  assign rd_rise = rdn_s2 & ~rdn_prev;
  // A pending THR byte moves to the shifter from IDLE or straight out of a finished stop bit.
  assign tx_load = ~uart_tbre &
                   ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_cnt == '0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdn_s1   <= 1'b1;
      rdn_s2   <= 1'b1;
      rdn_prev <= 1'b1;
      wrn_s1   <= 1'b1;
      wrn_s2   <= 1'b1;
      wrn_prev <= 1'b1;
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      data_d1  <= '0;
      data_d2  <= '0;
      wr_evt   <= 1'b0;
      wr_byte  <= '0;
    end else begin
      rdn_s1   <= uart_rdn;
      rdn_s2   <= rdn_s1;
      rdn_prev <= rdn_s2;
      wrn_s1   <= uart_wrn;
      wrn_s2   <= wrn_s1;
      wrn_prev <= wrn_s2;
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      data_d1  <= uart_data_i;
      data_d2  <= data_d1;
      wr_evt   <= wrn_s2 & ~wrn_prev;
      wr_byte  <= data_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      thr       <= '0;
      uart_tbre <= 1'b1;
      uart_tsre <= 1'b1;
      txd       <= 1'b1;
    end else begin
      if (tx_load) begin
        tx_state  <= S_START;
        tx_shift  <= thr;
        tx_cnt    <= BIT_TC;
        uart_tbre <= 1'b1;
        uart_tsre <= 1'b0;
        txd       <= 1'b0;
      end else begin
        case (tx_state)
          S_IDLE: txd <= 1'b1;
          S_START: begin
            if (tx_cnt == '0) begin
              tx_state <= S_DATA;
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= '0;
              tx_cnt   <= BIT_TC;
            end else begin
              tx_cnt <= tx_cnt - ONE;
            end
          end
          S_DATA: begin
            if (tx_cnt == '0) begin
              tx_cnt <= BIT_TC;
              if (tx_bit == 3'd7) begin
                tx_state <= S_STOP;
                txd      <= 1'b1;
              end else begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
              end
            end else begin
              tx_cnt <= tx_cnt - ONE;
            end
          end
          S_STOP: begin
            if (tx_cnt == '0) begin
              tx_state  <= S_IDLE;
              uart_tsre <= 1'b1;
            end else begin
              tx_cnt <= tx_cnt - ONE;
            end
          end
          default: tx_state <= S_IDLE;
        endcase
      end
      // THR is free again in the very cycle it is handed to the shifter.
      if (wr_evt && (uart_tbre || tx_load)) begin
        thr       <= wr_byte;
        uart_tbre <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state       <= S_IDLE;
      rx_cnt         <= '0;
      rx_bit         <= '0;
      rx_shift       <= '0;
      rbr            <= '0;
      uart_dataready <= 1'b0;
    end else begin
      if (rd_rise) uart_dataready <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rxd_s2) begin
            rx_state <= S_START;
            rx_cnt   <= HALF_TC;
          end
        end
        S_START: begin
          if (rx_cnt == '0) begin
            if (rxd_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_cnt   <= BIT_TC;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - ONE;
          end
        end
        S_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rxd_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_TC;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - ONE;
          end
        end
        S_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= S_IDLE;
            if (rxd_s2) begin
              rbr            <= rx_shift;
              uart_dataready <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - ONE;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_data_oe <= 1'b0;
      uart_data_o  <= '0;
    end else begin
      uart_data_oe <= ~rdn_s2;
      uart_data_o  <= rdn_s2 ? 8'h00 : rbr;
    end
  end

endmodule

// File: doc/cpld_uart_responder.md
Name: cpld_uart_responder

Overview:
Synthesizable stand-in for the board's CPLD serial controller: the responder end of the uart_rdn/uart_wrn/uart_dataready/uart_tbre/uart_tsre parallel handshake, bridging it to the direct serial pins txd/rxd (8N1, LSB first). Bus-side initiators (serial controller and its cloud testbench) see the same strobe/flag behaviour as the real CPLD. The shared 8-bit data lane is split into in/out/enable; the top level builds the tristate onto base_ram_data[7:0].

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  synchronous reset, active-low
uart_rdn  input  1  read strobe from initiator, active-low
uart_wrn  input  1  write strobe from initiator, active-low
uart_data_i  input  8  data lane as driven by initiator
uart_data_o  output  8  received byte presented to lane
uart_data_oe  output  1  1 = responder drives lane
uart_dataready  output  1  receive buffer holds unread byte
uart_tbre  output  1  transmit holding register empty
uart_tsre  output  1  transmit shift register empty (line idle)
txd  output  1  serial out
rxd  input  1  serial in

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): txd=1, uart_tbre=1, uart_tsre=1, uart_dataready=0, uart_data_oe=0, uart_data_o=0, RBR=0, THR empty, both FSMs IDLE, bit/baud counters 0. Reset mid-frame aborts the frame immediately; txd returns to 1 on the next cycle.
- uart_rdn, uart_wrn and rxd each pass through a 2-flop synchronizer (sync values reset to 1). uart_data_i is delayed by 2 flops so it stays aligned with synced wrn.
- Write: a rising edge on synced wrn (prev 0, now 1) is a write event.
  - If THR is empty, load THR from the delayed data and set tbre=0 on the next cycle.
  - If THR is full (tbre=0), drop the byte; no flag changes.
  - Latency: the pin wrn rising edge seen at clk edge n gives tbre=0 visible after edge n+3.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with THR full: move THR to the shifter in one cycle; tbre->1, tsre->0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end, go to IDLE with tsre=1 if THR is empty; otherwise reload from THR in the same cycle (tsre stays 0), so back-to-back frames have no idle gap.
  - A write event in the same cycle as a THR->shifter transfer loads THR (the transfer has priority; THR counts as empty).
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: synced rxd=0 moves to START.
  - START: wait CLKS_PER_BIT/2 (floor), then sample. 1 = glitch, return to IDLE with nothing stored; 0 = go to DATA.
  - DATA: sample 8 bits at bit centres (every CLKS_PER_BIT), LSB first.
  - STOP: sample at centre. 1 = write RBR, set dataready=1. 0 = framing error: discard the byte, leave RBR and dataready unchanged. Either way return to IDLE.
  - Overrun: a new byte arriving while dataready=1 overwrites RBR; dataready stays 1.
- Read:
  - While synced rdn=0: uart_data_oe=1 and uart_data_o=RBR, both registered, valid 3 edges after the pin falls.
  - On a synced rdn rising edge: oe->0 and dataready->0.
  - If an RX store happens in that same cycle, the store wins: dataready stays 1 with the new RBR.
- Simultaneous rdn=0 and wrn=0 is an initiator protocol error. Both paths still act independently; no arbitration.
- Counters are wide enough for CLKS_PER_BIT with no wrap inside a bit.

Test Plan:
- Reset, then idle 100 cycles -> txd=1, tbre=1, tsre=1, dataready=0, oe=0 throughout.
- CLKS_PER_BIT=8; pulse wrn with data_i=0x55 -> tbre=0 then 1 at the transfer; txd shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 8 cycles; tsre=1 after the stop bit.
- Write 0x12 then 0x34 immediately -> two contiguous frames with no idle gap. A third write while tbre=0 is dropped: only 2 frames appear.
- Drive rxd frame 0xA3 -> dataready=1. Pulse rdn -> data_o=0xA3 with oe=1 during the low phase; dataready=0 after the rdn rising edge.
- rxd low pulse of 3 cycles (less than half a bit) -> no store. Frame 0x5A with stop bit 0 -> discarded, dataready stays 0.
- Receive 0x11 then 0x22 unread -> RBR=0x22, dataready=1. Assert rst_n=0 mid-TX frame -> txd=1 and tsre=1 the next cycle.
